galois_sub_three_serial: RTL and testbench

Limb-serial modular subtractor computing diff = (num1 − num2 − num3) mod PRIME over the BN254 scalar field. It is the inverse-direction companion of the three-operand Galois adder in the MiMC datapath, used where round values must be removed from the state. Carry chains are limited to LIMB_BITS, so the block is a small FSM with valid/ready handshakes on both sides rather than a single 254-bit combinational path.

---
 rtl/galois_sub_three_serial.sv | 168 ++++++++++++++++
 tb/tb_galois_sub_three_serial.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/galois_sub_three_serial.sv
// galois_sub_three_serial
//
// Limb-serial modular subtractor: diff = (num1 - num2 - num3) mod PRIME.
// The 254-bit operation is split into LIMB_BITS-wide slices so that no carry
// chain is longer than one limb. It runs as two subtract passes. Each pass is
// followed by an optional fix-up pass that adds PRIME back when the subtraction
// went negative.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   operands valid
//   in_ready   block idle and able to accept operands
//   num1..3    N_BITS operands, each expected to be < PRIME
//   out_valid  diff valid; held until out_ready
//   out_ready  consumer accepts diff
//   diff       result in [0, PRIME); zero whenever out_valid is low
//
// Build option:
//   GALOIS_SUB_CONST_TIME_EN  when defined, both fix-up passes always run
//                             (adding PRIME or 0). Latency then does not
//                             depend on the data.

module galois_sub_three_serial #(
  parameter int N_BITS    = 254,
  parameter int LIMB_BITS = 64,
  parameter logic [N_BITS-1:0] PRIME =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] num1,
  input  logic [N_BITS-1:0] num2,
  input  logic [N_BITS-1:0] num3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] diff
);

  localparam int NUM_LIMBS = (N_BITS + LIMB_BITS - 1) / LIMB_BITS;
  localparam int W         = NUM_LIMBS * LIMB_BITS;
  localparam int CW        = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [CW-1:0] LAST_LIMB = CW'(NUM_LIMBS - 1);
  localparam logic [W-1:0]  PRIME_EXT = W'(PRIME);

`ifdef GALOIS_SUB_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SUB1 = 3'd1;
  localparam logic [2:0] S_FIX1 = 3'd2;
  localparam logic [2:0] S_SUB2 = 3'd3;
  localparam logic [2:0] S_FIX2 = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state, state_next;
  logic [CW-1:0]     cnt;
  logic              borrow;
  logic              neg;
  logic              in_ready_q;
  logic [W-1:0]      x, y, t, t_next;
  logic [N_BITS-1:0] num3_q;

  logic                 is_sub, is_fix, last, accept;
  logic [LIMB_BITS-1:0] x_limb, y_limb, t_limb, p_limb, limb_res;
  logic [LIMB_BITS:0]   sub_full, fix_full;
  logic                 limb_cout;

  // Single limb datapath shared by the subtract and fix-up passes. The borrow
  // register carries the borrow in SUBn and the carry in FIXn. In a subtract
  // pass, the extra top bit of the (LIMB_BITS+1)-bit difference is the
  // borrow-out.
  always_comb begin
    is_sub   = (state == S_SUB1) || (state == S_SUB2);
    is_fix   = (state == S_FIX1) || (state == S_FIX2);
    last     = (cnt == LAST_LIMB);
    accept   = (state == S_IDLE) && in_valid && in_ready_q;
    x_limb   = x[int'(cnt) * LIMB_BITS +: LIMB_BITS];
    y_limb   = y[int'(cnt) * LIMB_BITS +: LIMB_BITS];
    t_limb   = t[int'(cnt) * LIMB_BITS +: LIMB_BITS];
    p_limb   = neg ? PRIME_EXT[int'(cnt) * LIMB_BITS +: LIMB_BITS] : '0;
    sub_full = {1'b0, x_limb} - {1'b0, y_limb} - {{LIMB_BITS{1'b0}}, borrow};
    fix_full = {1'b0, t_limb} + {1'b0, p_limb} + {{LIMB_BITS{1'b0}}, borrow};
    limb_res  = is_fix ? fix_full[LIMB_BITS-1:0] : sub_full[LIMB_BITS-1:0];
    limb_cout = is_fix ? fix_full[LIMB_BITS] : sub_full[LIMB_BITS];
    t_next = t;
    if (is_sub || is_fix) begin
      t_next[int'(cnt) * LIMB_BITS +: LIMB_BITS] = limb_res;
    end
  end

  // Pass sequencing. A fix-up pass runs only after a negative subtraction,
  // unless constant-time mode forces it every time.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_SUB1;
      S_SUB1: if (last) state_next = (CONST_TIME || limb_cout) ? S_FIX1 : S_SUB2;
      S_FIX1: if (last) state_next = S_SUB2;
      S_SUB2: if (last) state_next = (CONST_TIME || limb_cout) ? S_FIX2 : S_DONE;
      S_FIX2: if (last) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State and datapath registers. The counter and borrow clear on every
  // state change, so each pass starts at limb 0 with no borrow. When the FSM
  // enters SUB2, the first-stage result (including the limb written on this
  // same edge) becomes the new minuend and num3 becomes the subtrahend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      in_ready_q <= 1'b0;
      cnt        <= '0;
      borrow     <= 1'b0;
      neg        <= 1'b0;
      x          <= '0;
      y          <= '0;
      t          <= '0;
      num3_q     <= '0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next == S_IDLE);
      if (state_next != state) begin
        cnt    <= '0;
        borrow <= 1'b0;
      end else if (is_sub || is_fix) begin
        cnt    <= cnt + CW'(1);
        borrow <= limb_cout;
      end
      if (is_sub || is_fix) begin
        t <= t_next;
      end
      if (is_sub && last) begin
        neg <= limb_cout;
      end
      if (accept) begin
        x      <= W'(num1);
        y      <= W'(num2);
        num3_q <= num3;
        neg    <= 1'b0;
      end else if ((state_next == S_SUB2) && (state != S_SUB2)) begin
        x <= t_next;
        y <= W'(num3_q);
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state == S_DONE);
  assign diff      = out_valid ? t[N_BITS-1:0] : '0;

  // The pad bits above N_BITS are zero for in-range operands and are never
  // driven out.
  generate
    if (W > N_BITS) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^t[W-1:N_BITS];
    end
  endgenerate

endmodule

// File: tb/tb_galois_sub_three_serial.sv
module tb_galois_sub_three_serial;

  localparam logic [253:0] P  =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [253:0] PM1 =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000000;

`ifdef GALOIS_SUB_CONST_TIME_EN
  localparam int LAT_NONE = 16;
  localparam int LAT_ONE  = 16;
`else
  localparam int LAT_NONE = 8;
  localparam int LAT_ONE  = 12;
`endif
  localparam int LAT_TWO = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [253:0] num1, num2, num3;
  logic         out_valid;
  logic         out_ready;
  logic [253:0] diff;

  int errors = 0;
  int checks = 0;

  galois_sub_three_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .num3      (num3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Waits for in_ready, presents the operands for one accept edge, and then
  // counts edges until out_valid is seen. It returns 41 when the bound expires.
  task automatic applyStimulus(input logic [253:0] a, input logic [253:0] b,
                               input logic [253:0] c, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    num1 = a; num2 = b; num3 = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 41;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    num1 = '0; num2 = '0; num3 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (diff !== '0) begin errors++; $display("[TB] FAIL reset_diff: got %0h expected 0", diff); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_case(input string name, input logic [253:0] a,
                           input logic [253:0] b, input logic [253:0] c,
                           input logic [253:0] exp_diff, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    applyStimulus(a, b, c, lat);
    checks++; if (lat !== exp_lat) begin errors++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
    checks++; if (diff !== exp_diff) begin errors++; $display("[TB] FAIL %s_diff: got %0h expected %0h", name, diff, exp_diff); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s_return_idle: got out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    applyStimulus(254'd10, 254'd3, 254'd2, lat);
    checks++; if (lat !== LAT_NONE) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, LAT_NONE); end
    checks++; if (diff !== 254'd5) begin errors++; $display("[TB] FAIL bp_diff: got %0h expected 5", diff); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || diff !== 254'd5 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold: cycle %0d got out_valid=%b diff=%0h in_ready=%b expected 1/5/0", i, out_valid, diff, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    num1 = 254'd0; num2 = 254'd1; num3 = 254'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Nine edges after the accept, the operation is inside the second subtract pass.
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || diff !== '0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_outputs: got out_valid=%b diff=%0h in_ready=%b expected 0/0/0", out_valid, diff, in_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", in_ready); end
    applyStimulus(254'd7, 254'd2, 254'd2, lat);
    checks++; if (lat !== LAT_NONE) begin errors++; $display("[TB] FAIL midreset_latency: got %0d expected %0d", lat, LAT_NONE); end
    checks++; if (diff !== 254'd3) begin errors++; $display("[TB] FAIL midreset_diff: got %0h expected 3", diff); end
    @(posedge clk); #1;
    // Reset while a result is held must drop it immediately.
    out_ready = 1'b0;
    applyStimulus(254'd9, 254'd1, 254'd1, lat);
    checks++; if (diff !== 254'd7) begin errors++; $display("[TB] FAIL done_reset_pre: got %0h expected 7", diff); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || diff !== '0) begin errors++; $display("[TB] FAIL done_reset_outputs: got out_valid=%b diff=%0h expected 0/0", out_valid, diff); end
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_input_hold();
    int  lat;
    bit  ready_seen;
    out_ready = 1'b1;
    ready_seen = 1'b0;
    num1 = 254'd20; num2 = 254'd5; num3 = 254'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 41;
    for (int i = 1; i <= 40; i++) begin
      num1 = 254'(i * 3 + 100);
      num2 = 254'(i + 1);
      num3 = 254'(i * 7);
      in_valid = i[0];
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
      if (in_ready) ready_seen = 1'b1;
    end
    in_valid = 1'b0;
    checks++; if (ready_seen !== 1'b0) begin errors++; $display("[TB] FAIL hold_busy_ready: got in_ready high while busy, expected 0"); end
    checks++; if (lat !== LAT_NONE) begin errors++; $display("[TB] FAIL hold_latency: got %0d expected %0d", lat, LAT_NONE); end
    checks++; if (diff !== 254'd11) begin errors++; $display("[TB] FAIL hold_diff: got %0h expected b", diff); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_idle: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_case("basic", 254'd5, 254'd3, 254'd1, 254'd1, LAT_NONE);
    test_case("single_wrap", 254'd0, 254'd1, 254'd0, PM1, LAT_ONE);
    test_case("double_wrap", 254'd0, PM1, PM1, 254'd2, LAT_TWO);
    test_case("exact_prime_wrap", 254'd3, 254'd4, PM1, 254'd0, LAT_ONE);
    test_backpressure();
    test_reset_mid();
    test_input_hold();
    if (P == '0) $display("[TB] unexpected zero modulus");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
